// File: rtl/lib_cpu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lib_cpu : shared types for the memory access unit                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lib_cpu;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } MEM_STATE;

  localparam int MEM_TIMEOUT_W = 8;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit_if : request/response bus to unified memory        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rsp_valid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_we, bus_addr, bus_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_we, bus_addr, bus_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_timeout_ctr : saturating cycle counter flagging an abort       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_timeout_ctr
  import lib_cpu::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [MEM_TIMEOUT_W-1:0] c_last_cnt = MEM_TIMEOUT_W'(TIMEOUT - 1);

  logic [MEM_TIMEOUT_W-1:0] count_q;
  logic [MEM_TIMEOUT_W-1:0] count_d;

  assign expired = (count_q == c_last_cnt);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit : sequences one controller memory access onto bus  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_access_unit
  import lib_cpu::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_or_d,
  input  logic               ireg_enab,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [ADDR_W-1:0]  alu_out,
  input  logic [DATA_W-1:0]  wdata,
  mem_access_unit_if.master  bus,
  output logic [DATA_W-1:0]  instr,
  output logic [DATA_W-1:0]  data_reg,
  output logic               busy,
  output logic               done,
  output logic               err
);

  MEM_STATE          state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              dest_q, dest_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] data_reg_q, data_reg_d;
  logic              err_q, err_d;

  logic misaligned;
  logic tmo_expired;

  assign misaligned = (addr_q[1:0] != 2'b00);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .enable  ((state_q == REQ) || (state_q == WAIT_RSP)),
    .expired (tmo_expired)
  );

  // A misaligned access parks in REQ for one cycle with valid masked off.
  assign bus.bus_req_valid = (state_q == REQ) && !misaligned;
  assign bus.bus_we        = we_q;
  assign bus.bus_addr      = addr_q;
  assign bus.bus_wdata     = wdata_q;

  assign instr    = instr_q;
  assign data_reg = data_reg_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    dest_d     = dest_q;
    instr_d    = instr_q;
    data_reg_d = data_reg_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (mem_wr || mem_rd) begin
          addr_d  = i_or_d ? alu_out : pc;
          we_d    = mem_wr;
          wdata_d = wdata;
          dest_d  = ireg_enab;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        // An accepted request beats a simultaneous expiry: it is already in flight.
        if (misaligned) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (bus.bus_req_ready) begin
          state_d = we_q ? DONE : WAIT_RSP;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT_RSP: begin
        if (bus.bus_rsp_valid) begin
          if (dest_q) begin
            instr_d = bus.bus_rdata;
          end else begin
            data_reg_d = bus.bus_rdata;
          end
          state_d = DONE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      dest_q     <= 1'b0;
      instr_q    <= '0;
      data_reg_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      dest_q     <= dest_d;
      instr_q    <= instr_d;
      data_reg_q <= data_reg_d;
      err_q      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_access_unit : randomized bench with transaction-level model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_access_unit;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int BUDGET  = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_or_d, ireg_enab, mem_rd, mem_wr;
  logic [ADDR_W-1:0] pc, alu_out;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] instr, data_reg;
  logic              busy, done, err;

  mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_or_d    (i_or_d),
    .ireg_enab (ireg_enab),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .pc        (pc),
    .alu_out   (alu_out),
    .wdata     (wdata),
    .bus       (bus.master),
    .instr     (instr),
    .data_reg  (data_reg),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Expected architectural state and per-transaction expectations
  logic [31:0] exp_instr, exp_data, exp_addr;
  logic        exp_err, exp_we;
  int          exp_done_c, exp_vcnt;

  // Observed per-transaction results
  logic [31:0] obs_addr, obs_wdata, obs_instr, obs_data;
  logic        obs_we, obs_err, obs_busy1, obs_err1, obs_after_ok;
  int          obs_done_c, obs_vcnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level outcome: when done appears (cycles after the strobe edge),
  // how many cycles valid is shown, and which register ends up holding what.
  task automatic model_txn(input logic wr, input logic iod, input logic ie,
                           input logic [31:0] pcv, input logic [31:0] aluv,
                           input int n_wait, input int rsp_lat, input logic [31:0] rdv);
    exp_addr = iod ? aluv : pcv;
    exp_we   = wr;
    exp_vcnt = 0;
    exp_err  = 1'b1;
    if (exp_addr[1:0] != 2'b00) begin
      exp_done_c = 2;
    end else if (n_wait >= TIMEOUT) begin
      exp_done_c = TIMEOUT + 1;
      exp_vcnt   = TIMEOUT;
    end else begin
      exp_vcnt = n_wait + 1;
      if (wr) begin
        exp_done_c = n_wait + 2;
        exp_err    = 1'b0;
      end else if (n_wait + rsp_lat < TIMEOUT) begin
        exp_done_c = n_wait + rsp_lat + 2;
        exp_err    = 1'b0;
        if (ie) exp_instr = rdv;
        else    exp_data  = rdv;
      end else begin
        exp_done_c = TIMEOUT + 1;
      end
    end
  endtask

  // Behaves as controller (holds strobes until done) and as memory.
  task automatic drive_txn(input logic rd, input logic wr, input logic iod, input logic ie,
                           input logic [31:0] pcv, input logic [31:0] aluv, input logic [31:0] wd,
                           input int n_wait, input int rsp_lat, input logic [31:0] rdv,
                           input logic spur);
    logic rsp_now;
    mem_rd = rd; mem_wr = wr; i_or_d = iod; ireg_enab = ie;
    pc = pcv; alu_out = aluv; wdata = wd;
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    obs_done_c = -1; obs_vcnt = 0; obs_addr = '0; obs_we = 1'b0; obs_wdata = '0;
    obs_err = 1'bx; obs_instr = 'x; obs_data = 'x;
    step();
    for (int c = 1; c <= BUDGET; c++) begin
      if (bus.bus_req_valid) begin
        if (obs_vcnt == 0) begin
          obs_addr = bus.bus_addr; obs_we = bus.bus_we; obs_wdata = bus.bus_wdata;
        end
        obs_vcnt++;
      end
      if (c == 1) begin
        obs_busy1 = busy; obs_err1 = err;
      end
      if (done) begin
        obs_done_c = c; obs_err = err; obs_instr = instr; obs_data = data_reg;
        break;
      end
      rsp_now = !wr && (c == 1 + n_wait + rsp_lat);
      bus.bus_req_ready = (c >= 1 + n_wait);
      bus.bus_rsp_valid = rsp_now || (spur && c == 1 + n_wait);
      bus.bus_rdata     = rsp_now ? rdv : $urandom;
      step();
    end
    mem_rd = 1'b0; mem_wr = 1'b0;
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    step();
    obs_after_ok = !done && !busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_rd = 0; mem_wr = 0; i_or_d = 0; ireg_enab = 0;
    pc = '0; alu_out = '0; wdata = '0;
    bus.bus_req_ready = 0; bus.bus_rsp_valid = 0; bus.bus_rdata = '0;
    step(); step();
    reset = 1'b0;
    checks++; if (bus.bus_req_valid !== 1'b0) $display("FAIL por_valid got %b want 0", bus.bus_req_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL por_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL por_done got %b want 0", done); else passes++;
    checks++; if ({instr, data_reg} !== 64'h0) $display("FAIL por_regs got %h/%h want 0/0", instr, data_reg); else passes++;
    // Hold a read in REQ, then reset it away
    mem_rd = 1'b1; pc = 32'h40; ireg_enab = 1'b1;
    step();
    checks++; if (bus.bus_req_valid !== 1'b1) $display("FAIL rst_req_valid got %b want 1", bus.bus_req_valid); else passes++;
    reset = 1'b1; mem_rd = 1'b0;
    step();
    checks++; if (bus.bus_req_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", bus.bus_req_valid); else passes++;
    checks++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL rst_mid_busy_err got %b%b want 00", busy, err); else passes++;
    step();
    reset = 1'b0;
    bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
    step();
    bus.bus_rsp_valid = 1'b0;
    step();
    checks++; if ({instr, data_reg} !== 64'h0) $display("FAIL rst_late_rsp got %h/%h want 0/0", instr, data_reg); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_late_busy got %b want 0", busy); else passes++;
    exp_instr = '0; exp_data = '0; exp_err = 1'b0;
  endtask

  task automatic test_fetch();
    model_txn(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 0, 1, 32'h8C43_0004);
    drive_txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 0, 1, 32'h8C43_0004, 1'b0);
    checks++; if (obs_addr !== 32'h40) $display("FAIL fetch_addr got %h want 00000040", obs_addr); else passes++;
    checks++; if (obs_instr !== 32'h8C43_0004) $display("FAIL fetch_instr got %h want 8c430004", obs_instr); else passes++;
    checks++; if (obs_data !== 32'h0) $display("FAIL fetch_data got %h want 0", obs_data); else passes++;
    checks++; if (obs_done_c !== 3) $display("FAIL fetch_done_cycle got %0d want 3", obs_done_c); else passes++;
    checks++; if (obs_after_ok !== 1'b1) $display("FAIL fetch_done_pulse got %b want 1", obs_after_ok); else passes++;
  endtask

  task automatic test_store_wait();
    model_txn(1'b1, 1'b1, 1'b0, 32'h0, 32'h100, 3, 1, 32'h0);
    drive_txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h100, 32'hDEAD_BEEF, 3, 1, 32'h0, 1'b0);
    checks++; if (obs_vcnt !== 4) $display("FAIL store_valid_cycles got %0d want 4", obs_vcnt); else passes++;
    checks++; if (obs_we !== 1'b1) $display("FAIL store_we got %b want 1", obs_we); else passes++;
    checks++; if (obs_addr !== 32'h100 || obs_wdata !== 32'hDEAD_BEEF) $display("FAIL store_addr_data got %h/%h want 00000100/deadbeef", obs_addr, obs_wdata); else passes++;
    checks++; if (obs_done_c !== 5) $display("FAIL store_done_cycle got %0d want 5", obs_done_c); else passes++;
    checks++; if (obs_data !== exp_data || obs_instr !== exp_instr) $display("FAIL store_regs got %h/%h want %h/%h", obs_instr, obs_data, exp_instr, exp_data); else passes++;
  endtask

  task automatic test_misaligned();
    model_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h102, 0, 1, 32'h1234_5678);
    drive_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h102, 32'h0, 0, 1, 32'h1234_5678, 1'b1);
    checks++; if (obs_vcnt !== 0) $display("FAIL mis_valid_cycles got %0d want 0", obs_vcnt); else passes++;
    checks++; if (obs_done_c !== 2) $display("FAIL mis_done_cycle got %0d want 2", obs_done_c); else passes++;
    checks++; if (obs_err !== 1'b1) $display("FAIL mis_err got %b want 1", obs_err); else passes++;
    checks++; if (obs_data !== exp_data || obs_instr !== exp_instr) $display("FAIL mis_regs got %h/%h want %h/%h", obs_instr, obs_data, exp_instr, exp_data); else passes++;
    model_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h104, 1, 2, 32'hCAFE_0001);
    drive_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h104, 32'h0, 1, 2, 32'hCAFE_0001, 1'b0);
    checks++; if (obs_err1 !== 1'b0 || obs_err !== 1'b0) $display("FAIL mis_err_clear got %b/%b want 0/0", obs_err1, obs_err); else passes++;
    checks++; if (obs_data !== 32'hCAFE_0001) $display("FAIL mis_next_data got %h want cafe0001", obs_data); else passes++;
  endtask

  task automatic test_timeout();
    model_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 0, 1000, 32'h5555_AAAA);
    drive_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'h0, 0, 1000, 32'h5555_AAAA, 1'b0);
    checks++; if (obs_done_c !== TIMEOUT + 1) $display("FAIL tmo_rd_done_cycle got %0d want %0d", obs_done_c, TIMEOUT + 1); else passes++;
    checks++; if (obs_err !== 1'b1) $display("FAIL tmo_rd_err got %b want 1", obs_err); else passes++;
    checks++; if (obs_instr !== exp_instr || obs_data !== exp_data) $display("FAIL tmo_rd_regs got %h/%h want %h/%h", obs_instr, obs_data, exp_instr, exp_data); else passes++;
    model_txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1000, 1, 32'h0);
    drive_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h1111_2222, 1000, 1, 32'h0, 1'b0);
    checks++; if (obs_vcnt !== TIMEOUT) $display("FAIL tmo_wr_valid_cycles got %0d want %0d", obs_vcnt, TIMEOUT); else passes++;
    checks++; if (obs_done_c !== TIMEOUT + 1 || obs_err !== 1'b1) $display("FAIL tmo_wr_done got %0d/%b want %0d/1", obs_done_c, obs_err, TIMEOUT + 1); else passes++;
  endtask

  task automatic test_simultaneous();
    model_txn(1'b1, 1'b1, 1'b0, 32'h0, 32'h400, 0, 1, 32'h0);
    drive_txn(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h400, 32'h7777_8888, 0, 1, 32'h0, 1'b1);
    checks++; if (obs_we !== 1'b1 || obs_vcnt !== 1) $display("FAIL both_we_vcnt got %b/%0d want 1/1", obs_we, obs_vcnt); else passes++;
    checks++; if (obs_done_c !== 2 || obs_err !== 1'b0) $display("FAIL both_done got %0d/%b want 2/0", obs_done_c, obs_err); else passes++;
    bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'hBAD0_BAD0;
    step();
    bus.bus_rsp_valid = 1'b0;
    step();
    checks++; if (data_reg !== exp_data || instr !== exp_instr) $display("FAIL idle_spurious_rsp got %h/%h want %h/%h", instr, data_reg, exp_instr, exp_data); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL idle_spurious_busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int          kind, n_wait, rsp_lat;
      logic        rd, wr, iod, ie, spur;
      logic [31:0] pcv, aluv, wd, rdv;
      kind    = $urandom_range(0, 2);
      rd      = (kind != 1);
      wr      = (kind != 0);
      iod     = 1'($urandom_range(0, 1));
      ie      = 1'($urandom_range(0, 1));
      spur    = 1'($urandom_range(0, 1));
      pcv     = $urandom & 32'hFFFF_FFFC;
      aluv    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) aluv[1:0] = 2'($urandom_range(1, 3));
      wd      = $urandom;
      rdv     = $urandom;
      n_wait  = $urandom_range(0, 3);
      rsp_lat = $urandom_range(1, 3);
      model_txn(wr, iod, ie, pcv, aluv, n_wait, rsp_lat, rdv);
      drive_txn(rd, wr, iod, ie, pcv, aluv, wd, n_wait, rsp_lat, rdv, spur);
      checks++; if (obs_done_c !== exp_done_c) $display("FAIL rnd%0d_done_cycle got %0d want %0d", i, obs_done_c, exp_done_c); else passes++;
      checks++; if (obs_vcnt !== exp_vcnt) $display("FAIL rnd%0d_valid_cycles got %0d want %0d", i, obs_vcnt, exp_vcnt); else passes++;
      checks++; if (obs_err !== exp_err) $display("FAIL rnd%0d_err got %b want %b", i, obs_err, exp_err); else passes++;
      checks++; if (obs_instr !== exp_instr || obs_data !== exp_data) $display("FAIL rnd%0d_regs got %h/%h want %h/%h", i, obs_instr, obs_data, exp_instr, exp_data); else passes++;
      checks++; if (obs_busy1 !== 1'b1 || obs_err1 !== 1'b0 || obs_after_ok !== 1'b1) $display("FAIL rnd%0d_status got %b%b%b want 101", i, obs_busy1, obs_err1, obs_after_ok); else passes++;
      if (exp_vcnt > 0) begin
        checks++; if (obs_addr !== exp_addr || obs_we !== exp_we) $display("FAIL rnd%0d_addr_we got %h/%b want %h/%b", i, obs_addr, obs_we, exp_addr, exp_we); else passes++;
        if (exp_we) begin
          checks++; if (obs_wdata !== wd) $display("FAIL rnd%0d_wdata got %h want %h", i, obs_wdata, wd); else passes++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_wait();
    test_misaligned();
    test_timeout();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Bus-side memory sequencer directly downstream of the multicycle controller. It consumes the controller's i_or_d and ireg_enab, plus read/write strobes, and selects the PC or ALU-out address. It runs a valid/ready request with a separate response handshake toward unified instruction/data memory, then latches results into the instruction register or the data register. It returns busy/done so the controller FSM holds its memory state until the access completes.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
TIMEOUT, 255, max cycles in REQ+WAIT_RSP before abort (8-bit counter; must be 1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_or_d  in  1  0: address = pc, 1: address = alu_out
ireg_enab  in  1  read result goes to instr (1) or data_reg (0)
mem_rd  in  1  read request strobe
mem_wr  in  1  write request strobe
pc  in  ADDR_W  program counter
alu_out  in  ADDR_W  ALU result register
wdata  in  DATA_W  store data
bus_req_valid  out  1  request valid
bus_req_ready  in  1  memory accepts request
bus_we  out  1  request is a write
bus_addr  out  ADDR_W  request address
bus_wdata  out  DATA_W  request write data
bus_rsp_valid  in  1  read data valid
bus_rdata  in  DATA_W  read data
instr  out  DATA_W  instruction register
data_reg  out  DATA_W  memory data register
busy  out  1  access in progress (state != IDLE)
done  out  1  one-cycle completion pulse
err  out  1  sticky error (misaligned or timeout); cleared on next accepted request

Behaviour:
- Reset (sync, active-high, clk edge): state IDLE; every output 0, including instr, data_reg, err and the timeout counter.
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE, when mem_wr|mem_rd:
  - latch addr = i_or_d ? alu_out : pc; latch we = mem_wr, wdata, and dest = ireg_enab.
  - clear err and counter.
  - If both strobes are high, the write wins and the read is dropped.
- Misaligned access (latched addr[1:0] != 0): no bus transaction; go to DONE with err=1; instr and data_reg unchanged.
- Otherwise go to REQ.
- REQ:
  - bus_req_valid=1; bus_we, bus_addr and bus_wdata stable from registers until handshake.
  - On valid&ready: a write goes to DONE (posted); a read goes to WAIT_RSP.
- WAIT_RSP:
  - On bus_rsp_valid, capture bus_rdata into instr (dest=1) or data_reg (dest=0), then go to DONE.
  - bus_rsp_valid arriving in the same cycle as the REQ handshake is ignored.
- Timeout:
  - Counter increments each cycle in REQ or WAIT_RSP.
  - When counter == TIMEOUT-1 without completion, go to DONE with err=1; registers unchanged; bus_req_valid drops.
- DONE: done=1 for exactly one cycle, then IDLE. The controller advances its FSM on done.
- Strobes while busy are ignored; the controller holds its strobes until done.
- Zero-wait read latency (ready=1 in REQ, rsp in the next cycle): strobe at edge 0, REQ at cycle 1, WAIT_RSP at cycle 2, captured at the end of cycle 2, done in cycle 3.
- Spurious bus_rsp_valid in IDLE, REQ or DONE: ignored.
- Reset mid-operation: bus_req_valid=0 from the next cycle; a late response is ignored; no register update.
- bus_addr and bus_wdata drive the latched values in all states; bus_req_valid is the only qualifier.

Decomposition:
- lib_cpu package gets:
  - typedef enum logic[1:0] MEM_STATE {IDLE, REQ, WAIT_RSP, DONE}
  - localparam MEM_TIMEOUT_W=8
- Sub-module mem_timeout_ctr:
  - ports: clear, enable, expired; parameter TIMEOUT.
  - Instantiated once.

Test Plan:
- Reset: hold reset 2 cycles mid-REQ -> bus_req_valid=0, busy=0, instr=0, data_reg=0, err=0 next cycle.
- Instruction fetch: i_or_d=0, pc=0x0000_0040, ireg_enab=1, mem_rd=1, ready=1, rsp next cycle with rdata=0x8C43_0004 -> bus_addr=0x40, instr=0x8C430004, data_reg unchanged, done pulses in cycle 3.
- Store with 3 wait states: i_or_d=1, alu_out=0x100, wdata=0xDEAD_BEEF, mem_wr=1, ready low 3 cycles -> valid held 4 cycles, bus_we=1, done after handshake, no WAIT_RSP.
- Misaligned: alu_out=0x102, mem_rd=1 -> no bus_req_valid, done in cycle 2, err=1; next aligned request clears err.
- Timeout: TIMEOUT=8, read accepted, rsp never arrives -> done with err=1 exactly 8 cycles after entering REQ; instr and data_reg unchanged.
- Simultaneous rd/wr: both high -> bus_we=1, single transaction; a spurious bus_rsp_valid in IDLE does not change data_reg.
